// File: rtl/prefetch_if_stage.sv
// Instruction-fetch stage: runs a fetch PC ahead of decode, keeps one memory read
// outstanding at most, and buffers {pc, inst} pairs in a DEPTH-entry FIFO.
module prefetch_if_stage #(
    parameter int unsigned      WIDTH    = 16,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 redirect_valid,
    input  logic [WIDTH-1:0]     redirect_addr,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_inst,
    output logic [WIDTH-1:0]     out_pc,
    output logic [WIDTH-1:0]     mem_addr,
    output logic                 mem_read,
    output logic [WIDTH/8-1:0]   mem_byte_enable,
    input  logic                 mem_resp,
    input  logic [WIDTH-1:0]     mem_rdata
);

    localparam int unsigned      AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned      CW      = AW + 1;
    localparam int unsigned      BW      = WIDTH / 8;
    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(BW);
    localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        SQUASH = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] fetch_pc;
    logic [WIDTH-1:0] fetch_pc_n;
    logic [WIDTH-1:0] mem_addr_n;
    logic             mem_read_n;

    logic [WIDTH-1:0] inst_q [DEPTH];
    logic [WIDTH-1:0] pc_q   [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [CW-1:0]    count;

    logic             pop_c;
    logic             push_c;
    logic             flush_c;
    logic             room_c;
    logic [CW-1:0]    count_after_c;
    logic [WIDTH-1:0] next_seq_pc_c;

    // A response is kept only when it completes a live (unsquashed) read and no redirect overrides it.
    assign push_c        = (state == FETCH) && mem_resp && !redirect_valid;
    assign pop_c         = out_valid && out_ready;
    assign count_after_c = count + CW'(push_c) - CW'(pop_c);
    assign room_c        = (count_after_c < DEPTH_C);
    assign next_seq_pc_c = mem_addr + PC_STEP;

    // Next-state and request control.
    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        mem_addr_n = mem_addr;
        mem_read_n = mem_read;
        flush_c    = 1'b0;

        case (state)
            IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_n = redirect_addr;
                    flush_c    = 1'b1;
                    mem_read_n = 1'b1;
                    mem_addr_n = redirect_addr;
                    state_n    = FETCH;
                end else if (room_c) begin
                    mem_read_n = 1'b1;
                    mem_addr_n = fetch_pc;
                    state_n    = FETCH;
                end
            end

            FETCH: begin
                if (mem_resp) begin
                    if (redirect_valid) begin
                        fetch_pc_n = redirect_addr;
                        flush_c    = 1'b1;
                        mem_read_n = 1'b1;
                        mem_addr_n = redirect_addr;
                    end else begin
                        fetch_pc_n = next_seq_pc_c;
                        if (room_c) begin
                            mem_read_n = 1'b1;
                            mem_addr_n = next_seq_pc_c;
                        end else begin
                            mem_read_n = 1'b0;
                            state_n    = IDLE;
                        end
                    end
                end else if (redirect_valid) begin
                    fetch_pc_n = redirect_addr;
                    flush_c    = 1'b1;
                    state_n    = SQUASH;
                end
            end

            SQUASH: begin
                if (redirect_valid) begin
                    fetch_pc_n = redirect_addr;
                    flush_c    = 1'b1;
                end
                // The squashed read's data is dropped; refetch from the latest target.
                if (mem_resp) begin
                    mem_read_n = 1'b1;
                    mem_addr_n = redirect_valid ? redirect_addr : fetch_pc;
                    state_n    = FETCH;
                end
            end

            default: begin
                state_n    = IDLE;
                mem_read_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            mem_addr <= RESET_PC;
            mem_read <= 1'b0;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            mem_addr <= mem_addr_n;
            mem_read <= mem_read_n;
        end
    end

    // Instruction FIFO; a flush overrides any pop in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (flush_c) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push_c) begin
                inst_q[tail] <= mem_rdata;
                pc_q[tail]   <= mem_addr;
                tail         <= tail + AW'(1);
            end
            if (pop_c) begin
                head <= head + AW'(1);
            end
            count     <= count_after_c;
            out_valid <= (count_after_c != '0);
        end
    end

    assign out_inst        = inst_q[head];
    assign out_pc          = pc_q[head];
    assign mem_byte_enable = '1;

endmodule

// File: tb/tb_prefetch_if_stage.sv
// Bench for prefetch_if_stage: variable-latency memory model plus an in-order
// instruction-stream scoreboard keyed on the redirect/reset target.
module tb_prefetch_if_stage;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned DEPTH  = 4;
    localparam logic [15:0] RST_PC = 16'h3000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [15:0] redirect_addr;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out_inst;
    logic [15:0] out_pc;
    logic [15:0] mem_addr;
    logic        mem_read;
    logic [1:0]  mem_byte_enable;
    logic        mem_resp;
    logic [15:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_pc;
    logic [15:0] last_pop_pc;
    int          pops;
    int          accepted;
    bit          squash_pending;
    bit          new_req;
    int          lat_mode;
    int          lat_fixed;
    int          cur_lat;
    int          wcnt;

    prefetch_if_stage #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_valid  (redirect_valid),
        .redirect_addr   (redirect_addr),
        .out_ready       (out_ready),
        .out_valid       (out_valid),
        .out_inst        (out_inst),
        .out_pc          (out_pc),
        .mem_addr        (mem_addr),
        .mem_read        (mem_read),
        .mem_byte_enable (mem_byte_enable),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC35A;
    endfunction

    // One clock: snapshot pre-edge, then score pops/responses and advance the memory model.
    task automatic step();
        logic        p_valid, p_ready, p_redir, p_read, p_resp;
        logic [15:0] p_pc, p_inst, p_raddr, p_addr;
        p_valid = out_valid;
        p_ready = out_ready;
        p_redir = redirect_valid;
        p_raddr = redirect_addr;
        p_read  = mem_read;
        p_resp  = mem_resp;
        p_addr  = mem_addr;
        p_pc    = out_pc;
        p_inst  = out_inst;
        @(posedge clk);
        #1;
        new_req = mem_read && (!p_read || p_resp);
        if (p_read && p_resp) begin
            if (!p_redir && !squash_pending) accepted++;
            squash_pending = 1'b0;
        end
        if (p_redir && p_read && !p_resp) squash_pending = 1'b1;

        if (p_redir) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush: out_valid=%0b required 0 after redirect to %h", out_valid, p_raddr);
            end
            exp_pc = p_raddr;
        end else if (p_valid && p_ready) begin
            checks++;
            if (p_pc !== exp_pc) begin
                errors++;
                $display("FAIL pop_pc: out_pc=%h required %h", p_pc, exp_pc);
            end
            checks++;
            if (p_inst !== mem_word(exp_pc)) begin
                errors++;
                $display("FAIL pop_inst: out_inst=%h required %h (pc %h)", p_inst, mem_word(exp_pc), exp_pc);
            end
            last_pop_pc = p_pc;
            exp_pc      = exp_pc + 16'd2;
            pops++;
        end

        if (p_read && !p_resp) begin
            checks++;
            if (mem_read !== 1'b1 || mem_addr !== p_addr) begin
                errors++;
                $display("FAIL req_hold: mem_read=%0b mem_addr=%h required 1/%h", mem_read, mem_addr, p_addr);
            end
        end

        if (!rst_n || !mem_read) begin
            mem_resp = 1'b0;
            wcnt     = 0;
        end else begin
            if (mem_resp) wcnt = 0;
            if (wcnt == 0) cur_lat = (lat_mode != 0) ? int'($urandom_range(1, 3)) : lat_fixed;
            wcnt++;
            mem_resp = (wcnt >= cur_lat);
        end
        mem_rdata = mem_resp ? mem_word(mem_addr) : 16'($urandom);
    endtask

    task automatic do_redirect(input logic [15:0] a);
        redirect_valid = 1'b1;
        redirect_addr  = a;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_pop(input int budget, output bit got);
        int p0;
        p0  = pops;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            step();
            if (pops != p0) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0 || mem_read !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: out_valid=%0b mem_read=%0b required 0/0", out_valid, mem_read);
        end
        checks++;
        if (mem_addr !== RST_PC) begin
            errors++;
            $display("FAIL reset_addr: mem_addr=%h required %h", mem_addr, RST_PC);
        end
        checks++;
        if (out_pc !== 16'h0000 || out_inst !== 16'h0000) begin
            errors++;
            $display("FAIL reset_data: out_pc=%h out_inst=%h required 0000/0000", out_pc, out_inst);
        end
        checks++;
        if (mem_byte_enable !== 2'b11) begin
            errors++;
            $display("FAIL byte_enable: mem_byte_enable=%b required 11", mem_byte_enable);
        end
        step();
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== RST_PC) begin
            errors++;
            $display("FAIL first_req: mem_read=%0b mem_addr=%h required 1/%h", mem_read, mem_addr, RST_PC);
        end
    endtask

    task automatic test_stream();
        logic [15:0] exp_req;
        int          p0;
        exp_req = RST_PC + 16'd2;
        p0      = pops;
        repeat (30) begin
            step();
            if (new_req) begin
                checks++;
                if (mem_addr !== exp_req) begin
                    errors++;
                    $display("FAIL stream_req: mem_addr=%h required %h", mem_addr, exp_req);
                end
                exp_req = exp_req + 16'd2;
            end
        end
        checks++;
        if (pops - p0 < 20) begin
            errors++;
            $display("FAIL stream_rate: pops=%0d required >=20", pops - p0);
        end
    endtask

    task automatic test_full();
        int a0;
        int p0;
        lat_mode  = 0;
        lat_fixed = 1;
        out_ready = 1'b0;
        do_redirect(16'h3000);
        a0 = accepted;
        repeat (12) step();
        checks++;
        if (accepted - a0 != int'(DEPTH)) begin
            errors++;
            $display("FAIL full_count: accepted=%0d required %0d", accepted - a0, DEPTH);
        end
        checks++;
        if (mem_read !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_stall: mem_read=%0b out_valid=%0b required 0/1", mem_read, out_valid);
        end
        p0        = pops;
        out_ready = 1'b1;
        step();
        checks++;
        if (pops != p0 + 1 || last_pop_pc !== 16'h3000) begin
            errors++;
            $display("FAIL full_first_pop: pops=%0d pc=%h required 1/3000", pops - p0, last_pop_pc);
        end
        checks++;
        if (mem_read !== 1'b1) begin
            errors++;
            $display("FAIL full_restart: mem_read=%0b required 1", mem_read);
        end
        repeat (10) step();
    endtask

    task automatic test_squash();
        bit found;
        bit got;
        lat_mode  = 0;
        lat_fixed = 3;
        out_ready = 1'b1;
        do_redirect(16'h3000);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (new_req && mem_addr === 16'h3006) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL squash_setup: request 3006 not seen, mem_addr=%h", mem_addr);
        end else begin
            do_redirect(16'h4000);
            checks++;
            if (mem_read !== 1'b1 || mem_addr !== 16'h3006) begin
                errors++;
                $display("FAIL squash_hold1: mem_read=%0b mem_addr=%h required 1/3006", mem_read, mem_addr);
            end
            step();
            checks++;
            if (mem_read !== 1'b1 || mem_addr !== 16'h3006) begin
                errors++;
                $display("FAIL squash_hold2: mem_read=%0b mem_addr=%h required 1/3006", mem_read, mem_addr);
            end
            step();
            checks++;
            if (mem_read !== 1'b1 || mem_addr !== 16'h4000) begin
                errors++;
                $display("FAIL squash_reissue: mem_read=%0b mem_addr=%h required 1/4000", mem_read, mem_addr);
            end
            wait_pop(30, got);
            checks++;
            if (!got || last_pop_pc !== 16'h4000) begin
                errors++;
                $display("FAIL squash_first_pc: got=%0b pc=%h required 1/4000", got, last_pop_pc);
            end
        end
    endtask

    task automatic test_redirect_resp();
        bit found;
        bit got;
        lat_mode  = 0;
        lat_fixed = 1;
        out_ready = 1'b1;
        found     = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_resp === 1'b1 && mem_read === 1'b1) found = 1'b1;
            else step();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rr_setup: no response cycle found, mem_resp=%0b", mem_resp);
        end else begin
            do_redirect(16'h5000);
            checks++;
            if (mem_read !== 1'b1 || mem_addr !== 16'h5000) begin
                errors++;
                $display("FAIL rr_issue: mem_read=%0b mem_addr=%h required 1/5000", mem_read, mem_addr);
            end
            wait_pop(20, got);
            checks++;
            if (!got || last_pop_pc !== 16'h5000) begin
                errors++;
                $display("FAIL rr_first_pc: got=%0b pc=%h required 1/5000", got, last_pop_pc);
            end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] got_pc [3];
        logic [15:0] want   [3];
        int          n;
        int          p0;
        want[0]   = 16'hFFFE;
        want[1]   = 16'h0000;
        want[2]   = 16'h0002;
        lat_mode  = 0;
        lat_fixed = 1;
        out_ready = 1'b1;
        do_redirect(16'hFFFE);
        n = 0;
        for (int i = 0; i < 40 && n < 3; i++) begin
            p0 = pops;
            step();
            if (pops != p0) begin
                got_pc[n] = last_pop_pc;
                n++;
            end
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL wrap_count: pops=%0d required 3", n);
        end
        for (int k = 0; k < n; k++) begin
            checks++;
            if (got_pc[k] !== want[k]) begin
                errors++;
                $display("FAIL wrap_pc%0d: out_pc=%h required %h", k, got_pc[k], want[k]);
            end
        end
    endtask

    task automatic test_random();
        int p0;
        lat_mode = 1;
        p0       = pops;
        repeat (400) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                redirect_valid = 1'b1;
                redirect_addr  = 16'($urandom_range(0, 32767) * 2);
            end
            step();
            redirect_valid = 1'b0;
        end
        checks++;
        if (pops - p0 < 50) begin
            errors++;
            $display("FAIL random_progress: pops=%0d required >=50", pops - p0);
        end
    endtask

    task automatic test_reset_mid();
        int a0;
        bit got;
        lat_mode  = 0;
        lat_fixed = 2;
        out_ready = 1'b0;
        do_redirect(16'h6000);
        a0 = accepted;
        for (int i = 0; i < 30 && (accepted - a0) < 2; i++) step();
        checks++;
        if (accepted - a0 != 2 || mem_read !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rmid_setup: accepted=%0d mem_read=%0b out_valid=%0b required 2/1/1",
                     accepted - a0, mem_read, out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (mem_read !== 1'b0 || out_valid !== 1'b0 || mem_addr !== RST_PC) begin
            errors++;
            $display("FAIL rmid_async: mem_read=%0b out_valid=%0b mem_addr=%h required 0/0/%h",
                     mem_read, out_valid, mem_addr, RST_PC);
        end
        mem_resp       = 1'b0;
        wcnt           = 0;
        squash_pending = 1'b0;
        exp_pc         = RST_PC;
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== RST_PC) begin
            errors++;
            $display("FAIL rmid_restart: mem_read=%0b mem_addr=%h required 1/%h", mem_read, mem_addr, RST_PC);
        end
        wait_pop(20, got);
        checks++;
        if (!got || last_pop_pc !== RST_PC) begin
            errors++;
            $display("FAIL rmid_first_pc: got=%0b pc=%h required 1/%h", got, last_pop_pc, RST_PC);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = 16'h0000;
        out_ready      = 1'b1;
        mem_resp       = 1'b0;
        mem_rdata      = 16'h0000;
        lat_mode       = 0;
        lat_fixed      = 1;
        cur_lat        = 1;
        wcnt           = 0;
        exp_pc         = RST_PC;
        last_pop_pc    = 16'h0000;
        pops           = 0;
        accepted       = 0;
        squash_pending = 1'b0;
        new_req        = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        test_reset();
        test_stream();
        test_full();
        test_squash();
        test_redirect_resp();
        test_wrap();
        test_random();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
